// File: rtl/fft8_sequencer.sv
// fft8_sequencer: in-place 8-point radix-2 DIT FFT controller around an external butterfly.
// Loads bit-reversed, runs 3x4 butterflies one per cycle, then streams bins in natural order.
`timescale 1ns/1ps
module fft8_sequencer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [8:0] i_in_re,
  input  logic [8:0] i_in_im,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [8:0] o_out_re,
  output logic [8:0] o_out_im,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_bf_w_re_mag,
  output logic       o_bf_w_re_neg,
  output logic [1:0] o_bf_w_im_mag,
  output logic       o_bf_w_im_neg,
  output logic [8:0] o_bf_xa_re,
  output logic [8:0] o_bf_xa_im,
  output logic [8:0] o_bf_xb_re,
  output logic [8:0] o_bf_xb_im,
  input  logic [8:0] i_bf_ya_re,
  input  logic [8:0] i_bf_ya_im,
  input  logic [8:0] i_bf_yb_re,
  input  logic [8:0] i_bf_yb_im
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [2:0]  n_r, n_s;
  logic [2:0]  m_r, m_s;
  logic [1:0]  s_r, s_s;
  logic [1:0]  b_r, b_s;
  logic [17:0] mem_r [8];

  logic [2:0]  b_ext_s, span_s, addr_a_s, addr_b_s, k_ext_s;
  logic [1:0]  k_s;
  logic        in_fire_s, out_fire_s;

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // Butterfly pair addresses and twiddle index from the current stage and butterfly number
  always_comb begin
    b_ext_s  = {1'b0, b_r};
    span_s   = 3'd1 << s_r;
    addr_a_s = ((b_ext_s >> s_r) << (s_r + 2'd1)) | (b_ext_s & (span_s - 3'd1));
    addr_b_s = addr_a_s + span_s;
    k_ext_s  = (b_ext_s & (span_s - 3'd1)) << (2'd2 - s_r);
    k_s      = k_ext_s[1:0];
  end

  // Twiddle code lookup for W8^k; zero outside COMPUTE
  always_comb begin
    o_bf_w_re_mag = 2'd0;
    o_bf_w_re_neg = 1'b0;
    o_bf_w_im_mag = 2'd0;
    o_bf_w_im_neg = 1'b0;
    if (state_r == ST_COMPUTE) begin
      case (k_s)
        2'd0: begin o_bf_w_re_mag = 2'd2; o_bf_w_re_neg = 1'b0; o_bf_w_im_mag = 2'd0; o_bf_w_im_neg = 1'b0; end
        2'd1: begin o_bf_w_re_mag = 2'd1; o_bf_w_re_neg = 1'b0; o_bf_w_im_mag = 2'd1; o_bf_w_im_neg = 1'b1; end
        2'd2: begin o_bf_w_re_mag = 2'd0; o_bf_w_re_neg = 1'b0; o_bf_w_im_mag = 2'd2; o_bf_w_im_neg = 1'b1; end
        2'd3: begin o_bf_w_re_mag = 2'd1; o_bf_w_re_neg = 1'b1; o_bf_w_im_mag = 2'd1; o_bf_w_im_neg = 1'b1; end
        default: begin o_bf_w_re_mag = 2'd0; o_bf_w_re_neg = 1'b0; o_bf_w_im_mag = 2'd0; o_bf_w_im_neg = 1'b0; end
      endcase
    end else begin
      o_bf_w_re_mag = 2'd0;
    end
  end

  // Butterfly operands read straight from the register file
  always_comb begin
    if (state_r == ST_COMPUTE) begin
      o_bf_xa_re = mem_r[addr_a_s][17:9];
      o_bf_xa_im = mem_r[addr_a_s][8:0];
      o_bf_xb_re = mem_r[addr_b_s][17:9];
      o_bf_xb_im = mem_r[addr_b_s][8:0];
    end else begin
      o_bf_xa_re = 9'd0;
      o_bf_xa_im = 9'd0;
      o_bf_xb_re = 9'd0;
      o_bf_xb_im = 9'd0;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_s    = state_r;
    n_s        = n_r;
    m_s        = m_r;
    s_s        = s_r;
    b_s        = b_r;
    in_fire_s  = (state_r == ST_LOAD) && i_in_valid;
    out_fire_s = (state_r == ST_OUTPUT) && i_out_ready;
    case (state_r)
      ST_LOAD: begin
        if (in_fire_s) begin
          n_s = n_r + 3'd1;
          if (n_r == 3'd7) begin
            state_s = ST_COMPUTE;
            s_s     = 2'd0;
            b_s     = 2'd0;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          n_s = n_r;
        end
      end
      ST_COMPUTE: begin
        b_s = b_r + 2'd1;
        if (b_r == 2'd3) begin
          if (s_r == 2'd2) begin
            state_s = ST_OUTPUT;
            s_s     = 2'd0;
            m_s     = 3'd0;
          end else begin
            s_s = s_r + 2'd1;
          end
        end else begin
          s_s = s_r;
        end
      end
      ST_OUTPUT: begin
        if (out_fire_s) begin
          m_s = m_r + 3'd1;
          if (m_r == 3'd7) begin
            state_s = ST_LOAD;
            n_s     = 3'd0;
          end else begin
            state_s = ST_OUTPUT;
          end
        end else begin
          m_s = m_r;
        end
      end
      default: begin
        state_s = ST_LOAD;
        n_s     = 3'd0;
        m_s     = 3'd0;
        s_s     = 2'd0;
        b_s     = 2'd0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_LOAD;
      n_r     <= 3'd0;
      m_r     <= 3'd0;
      s_r     <= 2'd0;
      b_r     <= 2'd0;
    end else begin
      state_r <= state_s;
      n_r     <= n_s;
      m_r     <= m_s;
      s_r     <= s_s;
      b_r     <= b_s;
    end
  end

  // Register file: bit-reversed load, then in-place butterfly write-back
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (in_fire_s) begin
        mem_r[bitrev3(n_r)] <= {i_in_re, i_in_im};
      end else if (state_r == ST_COMPUTE) begin
        mem_r[addr_a_s] <= {i_bf_ya_re, i_bf_ya_im};
        mem_r[addr_b_s] <= {i_bf_yb_re, i_bf_yb_im};
      end
    end
  end

  // Stream-side outputs decoded from registered state
  always_comb begin
    o_in_ready  = (state_r == ST_LOAD);
    o_out_valid = (state_r == ST_OUTPUT);
    o_busy      = (state_r == ST_COMPUTE);
    o_done      = out_fire_s && (m_r == 3'd7);
    if (state_r == ST_OUTPUT) begin
      o_out_re = mem_r[m_r][17:9];
      o_out_im = mem_r[m_r][8:0];
    end else begin
      o_out_re = 9'd0;
      o_out_im = 9'd0;
    end
  end

endmodule
